// File: rtl/wtb_poly_synthesis.sv
// Polyphonic wavetable synthesis path.
// Holds a per-voice parameter register file and one phase accumulator per
// voice. Each sample_rate strobe runs a fixed-length frame that steps every
// voice through one shared wavetable read port, a velocity multiplier and
// an envelope multiplier, then averages the voice samples into sample_out.
module wtb_poly_synthesis #(
  parameter int VOICES   = 4,
  parameter int PHASE_W  = 16,
  parameter int IDX_W    = 7,
  parameter int WFM_W    = 6,
  parameter int SAMPLE_W = 8,
  parameter int SCALE_W  = 7
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          sample_rate,
  input  logic                                          voice_we,
  input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] voice_sel,
  input  logic                                          voice_gate,
  input  logic [PHASE_W-1:0]                            voice_step,
  input  logic [WFM_W-1:0]                              voice_wfm,
  input  logic [SCALE_W-1:0]                            voice_vel,
  input  logic [SCALE_W-1:0]                            voice_env,
  output logic                                          rom_re,
  output logic [WFM_W+IDX_W-1:0]                        rom_addr,
  input  logic [SAMPLE_W-1:0]                           rom_data,
  output logic [SAMPLE_W-1:0]                           sample_out,
  output logic                                          sample_out_dv,
  output logic                                          busy,
  output logic                                          overrun
);

  localparam int VSEL_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int SHIFT  = $clog2(VOICES);
  localparam int ACC_W  = SAMPLE_W + SHIFT;
  localparam int ADDR_W = WFM_W + IDX_W;
  localparam int PROD_W = SAMPLE_W + SCALE_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    VEL   = 3'd2,
    ENV   = 3'd3,
    ACC   = 3'd4
  } state_t;

  state_t state_r, state_s;

  // Per-voice parameter register file and phase accumulators
  logic                gate_r  [VOICES];
  logic [PHASE_W-1:0]  step_r  [VOICES];
  logic [WFM_W-1:0]    wfm_r   [VOICES];
  logic [SCALE_W-1:0]  vel_r   [VOICES];
  logic [SCALE_W-1:0]  env_r   [VOICES];
  logic [PHASE_W-1:0]  phase_r [VOICES];

  // Frame datapath; the multiplier pipeline keeps only the top SAMPLE_W
  // bits of each product, which is all that the next stage consumes.
  logic [VSEL_W-1:0]   v_r;
  logic [SAMPLE_W-1:0] p1_r;
  logic [SAMPLE_W-1:0] p2_r;
  logic [ACC_W-1:0]    acc_r;

  logic                rom_re_r;
  logic [ADDR_W-1:0]   rom_addr_r;
  logic [SAMPLE_W-1:0] sample_out_r;
  logic                sample_out_dv_r;
  logic                overrun_r;

  logic                v_last_s;
  logic                fetch_start_s;
  logic [VSEL_W-1:0]   fetch_v_s;
  logic [ADDR_W-1:0]   fetch_addr_s;
  logic [ACC_W-1:0]    acc_next_s;

  assign rom_re        = rom_re_r;
  assign rom_addr      = rom_addr_r;
  assign sample_out    = sample_out_r;
  assign sample_out_dv = sample_out_dv_r;
  assign overrun       = overrun_r;
  assign busy          = (state_r != IDLE);

  // Next-state decode and the voice about to be fetched
  always_comb begin
    state_s       = state_r;
    v_last_s      = (v_r == VSEL_W'(VOICES - 1));
    fetch_start_s = 1'b0;
    fetch_v_s     = v_r;
    case (state_r)
      IDLE: begin
        fetch_v_s = '0;
        if (sample_rate) begin
          state_s       = FETCH;
          fetch_start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: state_s = VEL;
      VEL:   state_s = ENV;
      ENV:   state_s = ACC;
      ACC: begin
        fetch_v_s = v_r + VSEL_W'(1);
        if (v_last_s) begin
          state_s = IDLE;
        end else begin
          state_s       = FETCH;
          fetch_start_s = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Wavetable address for the next fetch (pre-increment phase) and the
  // running sum including the current voice's contribution
  always_comb begin
    fetch_addr_s = {wfm_r[fetch_v_s], phase_r[fetch_v_s][PHASE_W-1 -: IDX_W]};
    if (gate_r[v_r]) begin
      acc_next_s = acc_r + ACC_W'(p2_r);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Register file writes, note retrigger and per-voice phase advance
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        gate_r[i]  <= 1'b0;
        step_r[i]  <= '0;
        wfm_r[i]   <= '0;
        vel_r[i]   <= '0;
        env_r[i]   <= '0;
        phase_r[i] <= '0;
      end
    end else begin
      if (state_r == FETCH) begin
        phase_r[v_r] <= gate_r[v_r] ? (phase_r[v_r] + step_r[v_r]) : '0;
      end
      if (voice_we) begin
        gate_r[voice_sel] <= voice_gate;
        step_r[voice_sel] <= voice_step;
        wfm_r[voice_sel]  <= voice_wfm;
        vel_r[voice_sel]  <= voice_vel;
        env_r[voice_sel]  <= voice_env;
        // A fresh note-on restarts the waveform; it overrides a same-cycle advance
        if (voice_gate && !gate_r[voice_sel]) begin
          phase_r[voice_sel] <= '0;
        end
      end
    end
  end

  // Frame datapath, ROM request and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r             <= '0;
      p1_r            <= '0;
      p2_r            <= '0;
      acc_r           <= '0;
      rom_re_r        <= 1'b0;
      rom_addr_r      <= '0;
      sample_out_r    <= '0;
      sample_out_dv_r <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      // rom_re/rom_addr are set one cycle early so they are high during FETCH
      rom_re_r        <= fetch_start_s;
      sample_out_dv_r <= 1'b0;
      // Overrun is a registered flag: it follows the rejected strobe by a cycle
      overrun_r       <= sample_rate && (state_r != IDLE);
      if (fetch_start_s) begin
        rom_addr_r <= fetch_addr_s;
      end
      case (state_r)
        IDLE: begin
          if (sample_rate) begin
            acc_r <= '0;
            v_r   <= '0;
          end
        end
        VEL: begin
          p1_r <= SAMPLE_W'((PROD_W'(rom_data) * PROD_W'(vel_r[v_r])) >> SCALE_W);
        end
        ENV: begin
          p2_r <= SAMPLE_W'((PROD_W'(p1_r) * PROD_W'(env_r[v_r])) >> SCALE_W);
        end
        ACC: begin
          acc_r <= acc_next_s;
          if (v_last_s) begin
            sample_out_r    <= SAMPLE_W'(acc_next_s >> SHIFT);
            sample_out_dv_r <= 1'b1;
          end else begin
            v_r <= v_r + VSEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wtb_poly_synthesis.sv
// Self-checking bench for wtb_poly_synthesis: frame-level reference model,
// per-cycle output comparison, directed cases plus randomized frames.
module tb_wtb_poly_synthesis;

  localparam int V  = 4;
  localparam int PW = 16;
  localparam int IW = 7;
  localparam int WW = 6;
  localparam int SW = 8;
  localparam int KW = 7;
  localparam int FL = 4 * V;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_rate = 1'b0;
  logic          voice_we = 1'b0;
  logic [1:0]    voice_sel = '0;
  logic          voice_gate = 1'b0;
  logic [PW-1:0] voice_step = '0;
  logic [WW-1:0] voice_wfm = '0;
  logic [KW-1:0] voice_vel = '0;
  logic [KW-1:0] voice_env = '0;
  logic          rom_re;
  logic [WW+IW-1:0] rom_addr;
  logic [SW-1:0] rom_data = '0;
  logic [SW-1:0] sample_out;
  logic          sample_out_dv;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  wtb_poly_synthesis #(
    .VOICES(V), .PHASE_W(PW), .IDX_W(IW), .WFM_W(WW), .SAMPLE_W(SW), .SCALE_W(KW)
  ) dut (
    .clk(clk), .rst(rst), .sample_rate(sample_rate), .voice_we(voice_we),
    .voice_sel(voice_sel), .voice_gate(voice_gate), .voice_step(voice_step),
    .voice_wfm(voice_wfm), .voice_vel(voice_vel), .voice_env(voice_env),
    .rom_re(rom_re), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample_out(sample_out), .sample_out_dv(sample_out_dv), .busy(busy),
    .overrun(overrun)
  );

  // ---------------- wavetable ROM ----------------
  int rom_mode = 0;  // 0: all 0x80, 1: all 0xFF, 2: random table
  logic [SW-1:0] rom_tab [0:(1 << (WW + IW)) - 1];

  function automatic int rom_f(input int a);
    if (rom_mode == 0) return 8'h80;
    if (rom_mode == 1) return 8'hFF;
    return int'(rom_tab[a]);
  endfunction

  // One-cycle read latency; garbage when not read
  always @(posedge clk) rom_data <= rom_re ? SW'(rom_f(int'(rom_addr))) : SW'($urandom);

  // ---------------- checking bookkeeping ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_gate[V], m_step[V], m_wfm[V], m_vel[V], m_env[V], m_phase[V];
  int exp_addr[V];
  int pc = 0;           // number of rising edges so far
  int fs = -1000;       // edge at which the current frame's strobe was taken
  bit have_frame = 0;
  int pending = 0;      // result of the current frame
  int prev_out = 0;     // sample_out value before the current frame's dv
  int ovr_pc = -1;
  int re_cnt = 0, dv_cnt = 0, ovr_cnt = 0;

  // Whole frame at once: addresses, contributions, phase advance
  task automatic run_frame();
    int sum;
    int d;
    int c;
    sum = 0;
    for (int k = 0; k < V; k++) begin
      exp_addr[k] = m_wfm[k] * (1 << IW) + m_phase[k] / (1 << (PW - IW));
      d = rom_f(exp_addr[k]);
      c = ((d * m_vel[k]) / (1 << KW)) * m_env[k] / (1 << KW);
      if (m_gate[k] != 0) begin
        sum += c;
        m_phase[k] = (m_phase[k] + m_step[k]) % (1 << PW);
      end else begin
        m_phase[k] = 0;
      end
    end
    pending = sum / V;
  endtask

  task automatic model_step();
    int rel;
    int s;
    pc++;
    if (rst) begin
      for (int k = 0; k < V; k++) begin
        m_gate[k] = 0; m_step[k] = 0; m_wfm[k] = 0;
        m_vel[k] = 0; m_env[k] = 0; m_phase[k] = 0;
      end
      have_frame = 0;
      prev_out = 0;
      ovr_pc = -1;
    end else begin
      if (sample_rate) begin
        rel = pc - fs;
        if (have_frame && rel >= 1 && rel <= FL) begin
          ovr_pc = pc;
        end else begin
          if (have_frame) prev_out = pending;
          run_frame();
          fs = pc;
          have_frame = 1;
        end
      end
      if (voice_we) begin
        s = int'(voice_sel);
        if (voice_gate && m_gate[s] == 0) m_phase[s] = 0;
        m_gate[s] = int'(voice_gate);
        m_step[s] = int'(voice_step);
        m_wfm[s]  = int'(voice_wfm);
        m_vel[s]  = int'(voice_vel);
        m_env[s]  = int'(voice_env);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rom_re) re_cnt++;
    if (sample_out_dv) dv_cnt++;
    if (overrun) ovr_cnt++;
    model_step();
  end

  // Per-cycle comparison against the model, away from the rising edge
  task automatic compare_step();
    int rel;
    bit e_busy;
    bit e_re;
    bit e_dv;
    int e_out;
    rel = pc - fs + 1;
    e_busy = have_frame && rel >= 1 && rel <= FL;
    e_re   = e_busy && ((rel - 1) % 4 == 0);
    e_dv   = have_frame && rel == FL + 1;
    e_out  = (have_frame && rel >= FL + 1) ? pending : prev_out;
    chk("busy", int'(busy), int'(e_busy));
    chk("rom_re", int'(rom_re), int'(e_re));
    chk("dv", int'(sample_out_dv), int'(e_dv));
    chk("overrun", int'(overrun), (pc == ovr_pc) ? 1 : 0);
    chk("sample_out", int'(sample_out), e_out);
    if (e_re) chk("rom_addr", int'(rom_addr), exp_addr[(rel - 1) / 4]);
  endtask

  initial forever begin
    @(negedge clk);
    if (pc >= 1) compare_step();
  end

  // ---------------- stimulus helpers (enter and leave on a falling edge) ----------------
  task automatic wr(input int sel, input bit g, input int stp, input int w, input int vl, input int en);
    voice_we = 1'b1; voice_sel = 2'(sel); voice_gate = g;
    voice_step = PW'(stp); voice_wfm = WW'(w); voice_vel = KW'(vl); voice_env = KW'(en);
    @(negedge clk);
    voice_we = 1'b0;
  endtask

  task automatic strobe();
    sample_rate = 1'b1;
    @(negedge clk);
    sample_rate = 1'b0;
  endtask

  // Full frame; returns voice 0's address, leaves one idle cycle after dv
  task automatic frame(output int a0);
    strobe();
    a0 = int'(rom_addr);
    repeat (FL + 1) @(negedge clk);
  endtask

  int a, b0, b1, o, pos, nw;
  bit b2b;

  initial begin
    for (int i = 0; i < (1 << (WW + IW)); i++) rom_tab[i] = SW'($urandom);

    // Reset for two cycles
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_rom_re", int'(rom_re), 0);
    chk("rst_dv", int'(sample_out_dv), 0);
    chk("rst_overrun", int'(overrun), 0);

    // All gates off: four reads, one dv, silent output
    @(negedge clk);
    b0 = re_cnt; b1 = dv_cnt;
    frame(a);
    chk("off_rom_reads", re_cnt - b0, 4);
    chk("off_dv_count", dv_cnt - b1, 1);
    chk("off_sample", int'(sample_out), 0);

    // Single voice at midscale
    wr(0, 1'b1, 16'h0200, 3, 127, 127);
    frame(a);
    chk("mid_addr1", a, 13'h180);
    chk("mid_sample", int'(sample_out), 31);
    chk("mid_model", pending, 31);
    frame(a);
    chk("mid_addr2", a, 13'h181);

    // Four voices at full scale
    rom_mode = 1;
    for (int k = 0; k < V; k++) wr(k, 1'b1, 16'h0100, k, 127, 127);
    frame(a);
    chk("full_sample", int'(sample_out), 251);
    chk("full_model", pending, 251);

    // Phase wrap, 1->1 rewrite, retrigger
    rom_mode = 0;
    wr(0, 1'b0, 16'h8000, 0, 127, 127);
    wr(0, 1'b1, 16'h8000, 0, 127, 127);
    frame(a); chk("wrap_idx0", a, 0);
    frame(a); chk("wrap_idx1", a, 64);
    frame(a); chk("wrap_idx2", a, 0);
    wr(0, 1'b1, 16'h8000, 0, 127, 127);
    frame(a); chk("keep_idx", a, 64);
    frame(a); chk("keep_idx2", a, 0);
    wr(0, 1'b0, 16'h8000, 0, 127, 127);
    wr(0, 1'b1, 16'h8000, 0, 127, 127);
    frame(a); chk("retrig_idx", a, 0);

    // Overrun: second strobe five cycles in; phase now 0x8000, step 0x0200
    wr(0, 1'b1, 16'h0200, 0, 127, 127);
    b0 = ovr_cnt; b1 = dv_cnt;
    strobe();
    chk("ovr_idx", int'(rom_addr), 64);
    repeat (3) @(negedge clk);
    strobe();
    repeat (FL - 3) @(negedge clk);
    chk("ovr_pulses", ovr_cnt - b0, 1);
    chk("ovr_dv_count", dv_cnt - b1, 1);
    frame(a);
    chk("ovr_next_idx", a, 65);

    // Reset mid-frame
    b1 = dv_cnt;
    strobe();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_dv", dv_cnt - b1, 0);
    chk("midrst_sample", int'(sample_out), 0);
    frame(a);
    chk("midrst_idx", a, 0);

    // Randomized frames with overruns and back-to-back strobes
    rom_mode = 2;
    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!b2b) begin
        nw = $urandom_range(0, 3);
        for (int j = 0; j < nw; j++)
          wr($urandom_range(0, V - 1), ($urandom_range(0, 3) != 0), $urandom,
             $urandom, $urandom_range(0, 127), $urandom_range(0, 127));
      end
      strobe();
      pos = 1;
      if ($urandom_range(0, 3) == 0) begin
        o = $urandom_range(1, FL);
        repeat (o - pos) @(negedge clk);
        strobe();
        pos = o + 1;
      end
      b2b = ($urandom_range(0, 2) == 0);
      if (b2b) repeat (FL + 1 - pos) @(negedge clk);
      else     repeat (FL + 2 - pos + $urandom_range(0, 3)) @(negedge clk);
    end

    repeat (FL + 4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
